// File: rtl/switch_csr_mailbox.sv
// Avalon-MM CSR bridge between the HPS driver and the switch ports: per-port
// descriptor pulses toward ingress, per-port egress FIFOs popped by software reads,
// sticky overflow status, a level interrupt and the experiment-mode control.
module switch_csr_mailbox #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned RX_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        chipselect,
    input  logic                        write,
    input  logic                        read,
    input  logic [ADDR_W-1:0]           address,
    input  logic [DATA_W-1:0]           writedata,
    output logic [DATA_W-1:0]           readdata,
    input  logic [NUM_PORTS-1:0]        eg_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] eg_data,
    output logic [NUM_PORTS-1:0]        out_en,
    output logic [DATA_W-1:0]           out_data,
    output logic                        experimenting,
    output logic                        irq
);

    localparam int unsigned PtrW = $clog2(RX_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(RX_DEPTH);
    // Implemented CTRL bits: mode [1:0], STATUS count select [7:4], irq mask.
    localparam logic [DATA_W-1:0] CtrlMask =
        DATA_W'(((32'd1 << NUM_PORTS) - 32'd1) << 8) | DATA_W'(32'hF3);

    logic [DATA_W-1:0] mem_q [NUM_PORTS][RX_DEPTH];
    logic [NUM_PORTS-1:0][PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NUM_PORTS-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] ovf_q, ovf_d, push, pop, nonempty, full;
    logic [DATA_W-1:0] ctrl_q, ctrl_d, rdata_d, rdata_q, out_data_q, out_data_d;
    logic [NUM_PORTS-1:0] out_en_q, out_en_d, port_wr, port_rd;
    logic irq_q;
    logic wr_acc, rd_acc, ctrl_wr, clr_wr;
    logic [CntW-1:0] sel_cnt;
    logic [3:0] sel_sat;
    logic [31:0] status;

    assign wr_acc = chipselect && write;
    assign rd_acc = chipselect && read;
    assign ctrl_wr = wr_acc && (address == ADDR_W'(0));
    assign clr_wr = wr_acc && (address == ADDR_W'(2));

    // Decode per-port descriptor writes and mailbox reads.
    always_comb begin
        port_wr = '0;
        port_rd = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_wr[i] = wr_acc && (address == ADDR_W'(3 + i));
            port_rd[i] = rd_acc && (address == ADDR_W'(3 + i));
        end
    end

    // FIFO bookkeeping: pop is evaluated first so a full FIFO can accept a push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        push     = '0;
        pop      = '0;
        nonempty = '0;
        full     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            full[i]     = (cnt_q[i] == FullCnt);
            pop[i]      = port_rd[i] && nonempty[i];
            push[i]     = eg_valid[i] && (!full[i] || pop[i]);
            if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(1);
            if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(1);
            if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + CntW'(1);
            if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - CntW'(1);
            if (clr_wr && writedata[8 + i]) ovf_d[i] = 1'b0;
            // A dropped word in the same cycle as CLEAR keeps the bit set.
            if (eg_valid[i] && !push[i]) ovf_d[i] = 1'b1;
        end
    end

    // Count of the port selected by CTRL[7:4], saturated to the 4-bit field.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ctrl_q[7:4] == 4'(i)) sel_cnt = cnt_q[i];
        end
        sel_sat = (32'(sel_cnt) > 32'd15) ? 4'hF : 4'(sel_cnt);
    end

    // STATUS word assembly and read-data mux (empty port reads return 0).
    always_comb begin
        status = '0;
        status[NUM_PORTS-1:0] = nonempty;
        status[8 +: NUM_PORTS] = ovf_q;
        status[16 +: NUM_PORTS] = full;
        status[24 +: 4] = sel_sat;
        rdata_d = '0;
        if (rd_acc) begin
            if (address == ADDR_W'(0)) rdata_d = ctrl_q;
            else if (address == ADDR_W'(1)) rdata_d = DATA_W'(status);
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (port_rd[i] && nonempty[i]) rdata_d = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    // CTRL write and one-cycle descriptor pulse generation.
    always_comb begin
        ctrl_d     = ctrl_q;
        out_en_d   = port_wr;
        out_data_d = out_data_q;
        if (ctrl_wr) ctrl_d = writedata & CtrlMask;
        if (|port_wr) out_data_d = writedata;
    end

    // Control/status state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= '0;
            ctrl_q     <= '0;
            rdata_q    <= '0;
            out_en_q   <= '0;
            out_data_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            out_en_q   <= out_en_d;
            out_data_q <= out_data_d;
            irq_q      <= |(nonempty & ctrl_q[8 +: NUM_PORTS]);
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= eg_data[i*DATA_W +: DATA_W];
        end
    end

    assign readdata      = rdata_q;
    assign out_en        = out_en_q;
    assign out_data      = out_data_q;
    assign experimenting = (ctrl_q[1:0] == 2'd2);
    assign irq           = irq_q;

endmodule

// File: tb/tb_switch_csr_mailbox.sv
// Bench for switch_csr_mailbox: directed steps then random traffic, each cycle
// checked against a queue-based model of the register map and mailboxes.
module tb_switch_csr_mailbox;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset, chipselect, write, read;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata, readdata, out_data;
    logic [NP-1:0] eg_valid, out_en;
    logic [NP*DW-1:0] eg_data;
    logic experimenting, irq;

    always #5 clk = ~clk;

    switch_csr_mailbox #(
        .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .RX_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .eg_valid(eg_valid), .eg_data(eg_data), .out_en(out_en), .out_data(out_data),
        .experimenting(experimenting), .irq(irq)
    );

    // Reference model state.
    logic [DW-1:0] mq [NP][$];
    logic [NP-1:0] ovf_m, out_en_m;
    logic [DW-1:0] ctrl_m, out_data_m;
    logic irq_m;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] status_m();
        logic [DW-1:0] s = '0;
        int sel, c;
        for (int p = 0; p < NP; p++) begin
            s[p] = (mq[p].size() != 0);
            s[8 + p] = ovf_m[p];
            s[16 + p] = (mq[p].size() == DEPTH);
        end
        sel = int'(ctrl_m[7:4]);
        if (sel < NP) begin
            c = mq[sel].size();
            s[27:24] = (c > 15) ? 4'hF : 4'(c);
        end
        return s;
    endfunction

    function automatic logic [NP*DW-1:0] lane(input int p, input logic [DW-1:0] w);
        logic [NP*DW-1:0] v = '0;
        v[p*DW +: DW] = w;
        return v;
    endfunction

    // One bus/egress cycle: drive, advance model at the edge, check 1 time unit later.
    task automatic step(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [NP-1:0] egv,
                        input logic [NP*DW-1:0] egd);
        logic [DW-1:0] exp_rd;
        logic [NP-1:0] ne;
        int ai;
        chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
        eg_valid = egv; eg_data = egd;
        @(posedge clk);
        ai = int'(a);
        for (int p = 0; p < NP; p++) ne[p] = (mq[p].size() != 0);
        irq_m = |(ne & ctrl_m[8 +: NP]);
        exp_rd = '0;
        if (cs && rd) begin
            if (ai == 0) exp_rd = ctrl_m;
            else if (ai == 1) exp_rd = status_m();
            else if (ai >= 3 && ai < 3 + NP && mq[ai-3].size() != 0)
                exp_rd = mq[ai-3].pop_front();
        end
        if (cs && wr && ai == 2) ovf_m = ovf_m & ~wd[8 +: NP];
        for (int p = 0; p < NP; p++) begin
            if (egv[p]) begin
                if (mq[p].size() < DEPTH) mq[p].push_back(egd[p*DW +: DW]);
                else ovf_m[p] = 1'b1;
            end
        end
        out_en_m = '0;
        if (cs && wr) begin
            if (ai == 0) ctrl_m = wd;
            else if (ai >= 3 && ai < 3 + NP) begin
                out_en_m[ai-3] = 1'b1;
                out_data_m = wd;
            end
        end
        #1;
        if (cs && rd) chk("readdata", readdata, exp_rd);
        chk("out_en", DW'(out_en), DW'(out_en_m));
        chk("out_data", out_data, out_data_m);
        chk("irq", DW'(irq), DW'(irq_m));
        chk("experimenting", DW'(experimenting), DW'(ctrl_m[1:0] == 2'd2));
    endtask

    task automatic rd_reg(input int a);
        step(1'b1, 1'b1, 1'b0, AW'(a), '0, '0, '0);
    endtask

    task automatic wr_reg(input int a, input logic [DW-1:0] d);
        step(1'b1, 1'b0, 1'b1, AW'(a), d, '0, '0);
    endtask

    task automatic push(input int p, input logic [DW-1:0] w);
        step(1'b0, 1'b0, 1'b0, '0, '0, NP'(1 << p), lane(p, w));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; eg_valid = '0; eg_data = '0;
        repeat (2) @(posedge clk);
        for (int p = 0; p < NP; p++) mq[p].delete();
        ovf_m = '0; ctrl_m = '0; out_en_m = '0; out_data_m = '0; irq_m = 1'b0;
        #1;
        reset = 1'b0;
        chk("rst_readdata", readdata, '0);
        chk("rst_out_en", DW'(out_en), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_irq", DW'(irq), '0);
        chk("rst_experimenting", DW'(experimenting), '0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rw;
        do_reset();

        // All mapped registers read zero after reset.
        for (int a = 0; a < 3 + NP; a++) begin
            rd_reg(a);
            chk("rst_reg", readdata, '0);
        end

        // Mode register drives experimenting.
        wr_reg(0, 32'h2);
        chk("exp_on", DW'(experimenting), 32'd1);
        wr_reg(0, 32'h1);
        chk("exp_off", DW'(experimenting), 32'd0);

        // Descriptor pulses.
        wr_reg(4, 32'hDEADBEEF);
        chk("pulse1_en", DW'(out_en), 32'b0010);
        chk("pulse1_data", out_data, 32'hDEADBEEF);
        idle();
        chk("pulse1_end", DW'(out_en), 32'd0);
        wr_reg(6, 32'h12345678);
        wr_reg(3, 32'hCAFEF00D);
        chk("b2b_en", DW'(out_en), 32'b0001);

        // Port 2 mailbox ordering and empty read.
        push(2, 32'h11); push(2, 32'h22); push(2, 32'h33);
        rd_reg(1);
        chk("p2_nonempty", DW'(readdata[2]), 32'd1);
        rd_reg(5); chk("p2_w0", readdata, 32'h11);
        rd_reg(5); chk("p2_w1", readdata, 32'h22);
        rd_reg(5); chk("p2_w2", readdata, 32'h33);
        rd_reg(5); chk("p2_empty", readdata, 32'h0);
        rd_reg(1);
        chk("p2_drained", DW'(readdata[2]), 32'd0);

        // Port 0 overflow, full, drain and clear.
        for (int k = 1; k <= 9; k++) push(0, DW'(k));
        rd_reg(1);
        chk("p0_ovf", DW'(readdata[8]), 32'd1);
        chk("p0_full", DW'(readdata[16]), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            rd_reg(3);
            chk("p0_word", readdata, DW'(k));
        end
        wr_reg(2, 32'h100);
        rd_reg(1);
        chk("p0_ovf_clr", DW'(readdata[8]), 32'd0);

        // Interrupt follows nonempty & mask, one cycle late.
        wr_reg(0, 32'h0100);
        push(0, 32'hA5);
        idle();
        chk("irq_set", DW'(irq), 32'd1);
        rd_reg(3);
        idle();
        chk("irq_clr", DW'(irq), 32'd0);

        // Full port 1 with simultaneous push and pop.
        wr_reg(0, 32'h0110);
        for (int k = 0; k < DEPTH; k++) push(1, 32'h100 + DW'(k));
        step(1'b1, 1'b1, 1'b0, AW'(4), '0, 4'b0010, lane(1, 32'hBEEF));
        chk("p1_head", readdata, 32'h100);
        rd_reg(1);
        chk("p1_count", DW'(readdata[27:24]), 32'd8);
        chk("p1_no_ovf", DW'(readdata[9]), 32'd0);

        // Push on an empty port during a read of it: no bypass.
        step(1'b1, 1'b1, 1'b0, AW'(5), '0, 4'b0100, lane(2, 32'h77));
        chk("no_bypass", readdata, 32'h0);
        rd_reg(5);
        chk("no_bypass_word", readdata, 32'h77);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            ra = ($urandom_range(0, 1) == 0) ? AW'(3 + $urandom_range(0, NP - 1))
                                             : AW'($urandom_range(0, 15));
            rw = $urandom();
            if (ra == AW'(0)) rw = rw & 32'h0FF3;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, ra, rw,
                 NP'($urandom()) & NP'($urandom()),
                 {$urandom(), $urandom(), $urandom(), $urandom()});
        end

        // Reset mid-operation discards buffered words.
        for (int k = 0; k < 3; k++) push(3, DW'(k + 50));
        do_reset();
        rd_reg(1);
        chk("rst2_status", readdata, '0);
        for (int p = 0; p < NP; p++) begin
            rd_reg(3 + p);
            chk("rst2_port", readdata, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
